// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a small transmit FIFO.
//
// Bytes written with tx_stb_i are queued in a FIFO_DEPTH-entry FIFO and sent
// as 8N1 frames (start, 8 data bits LSB first, stop), each bit lasting
// CLKS_PER_BIT clock cycles.  Queued bytes go out back to back with no idle
// gap between one stop bit and the next start bit.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11-bit frame).
//
// Ports:
//   clk_i      single clock, rising edge
//   rst_i      synchronous active-high reset
//   tx_dat_i   byte to queue
//   tx_stb_i   write strobe, one byte per high cycle; dropped when full
//   tx_full_o  FIFO holds FIFO_DEPTH entries (registered)
//   tx_level_o FIFO occupancy (registered)
//   tx_busy_o  FIFO non-empty or a frame in progress (registered)
//   tx_o       serial line, idle high (registered)
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [7:0]                  tx_dat_i,
   input  logic                        tx_stb_i,
   output logic                        tx_full_o,
   output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
   output logic                        tx_busy_o,
   output logic                        tx_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;

   // Even parity: the bit that makes the total number of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [LW-1:0] level_r, level_nxt_s;
   logic          full_r, busy_r, busy_nxt_s;
   logic [2:0]    state_r, state_nxt_s;
   logic [15:0]   baud_r, baud_nxt_s;
   logic [2:0]    bit_r, bit_nxt_s;
   logic [7:0]    shift_r, shift_nxt_s;
   logic          tx_r, tx_nxt_s;
   logic          push_s, pop_s, baud_end_s;
   logic [7:0]    head_s;
`ifdef UART_TX_PARITY_EN
   logic          par_r;
`endif

   // Full is the registered flag, so a strobe while full is dropped even if
   // a pop happens in the same cycle.
   assign push_s      = tx_stb_i & ~full_r & ~rst_i;
   assign head_s      = mem_r[rd_ptr_r];
   assign baud_end_s  = (baud_r == BAUD_LAST);
   assign level_nxt_s = level_r + LW'(push_s) - LW'(pop_s);
   assign busy_nxt_s  = (level_nxt_s != {LW{1'b0}}) | (state_nxt_s != ST_IDLE);

   // Frame sequencer: next state, baud/bit counters, shift register, line.
   always_comb begin
      state_nxt_s = state_r;
      baud_nxt_s  = baud_r + 16'd1;
      bit_nxt_s   = bit_r;
      shift_nxt_s = shift_r;
      tx_nxt_s    = tx_r;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            baud_nxt_s = 16'd0;
            if (level_r != {LW{1'b0}}) begin
               pop_s       = 1'b1;
               shift_nxt_s = head_s;
               state_nxt_s = ST_START;
               tx_nxt_s    = 1'b0;
            end else begin
               tx_nxt_s    = 1'b1;
            end
         end
         ST_START: begin
            if (baud_end_s) begin
               // First data bit leaves the shifter on entry to DATA.
               state_nxt_s = ST_DATA;
               baud_nxt_s  = 16'd0;
               bit_nxt_s   = 3'd0;
               tx_nxt_s    = shift_r[0];
               shift_nxt_s = {1'b0, shift_r[7:1]};
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_nxt_s = 16'd0;
               if (bit_r == 3'd7) begin
                  bit_nxt_s   = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_nxt_s = ST_PARITY;
                  tx_nxt_s    = par_r;
`else
                  state_nxt_s = ST_STOP;
                  tx_nxt_s    = 1'b1;
`endif
               end else begin
                  bit_nxt_s   = bit_r + 3'd1;
                  tx_nxt_s    = shift_r[0];
                  shift_nxt_s = {1'b0, shift_r[7:1]};
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_end_s) begin
               state_nxt_s = ST_STOP;
               baud_nxt_s  = 16'd0;
               tx_nxt_s    = 1'b1;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (baud_end_s) begin
               baud_nxt_s = 16'd0;
               // Chain straight into the next start bit when data is waiting.
               if (level_r != {LW{1'b0}}) begin
                  pop_s       = 1'b1;
                  shift_nxt_s = head_s;
                  state_nxt_s = ST_START;
                  tx_nxt_s    = 1'b0;
               end else begin
                  state_nxt_s = ST_IDLE;
                  tx_nxt_s    = 1'b1;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            baud_nxt_s  = 16'd0;
            bit_nxt_s   = 3'd0;
            tx_nxt_s    = 1'b1;
         end
      endcase
   end

   // FIFO storage; validity is tracked by the pointers and level, so the
   // array itself needs no reset.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= tx_dat_i;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         baud_r   <= 16'd0;
         bit_r    <= 3'd0;
         shift_r  <= 8'h00;
         tx_r     <= 1'b1;
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
         full_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         baud_r   <= baud_nxt_s;
         bit_r    <= bit_nxt_s;
         shift_r  <= shift_nxt_s;
         tx_r     <= tx_nxt_s;
         wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
         rd_ptr_r <= pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
         level_r  <= level_nxt_s;
         full_r   <= (level_nxt_s == LEVEL_FULL);
         busy_r   <= busy_nxt_s;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity of the byte being sent, captured as it is popped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         par_r <= 1'b0;
      end else if (pop_s) begin
         par_r <= even_parity(head_s);
      end else begin
         par_r <= par_r;
      end
   end
`endif

   assign tx_o       = tx_r;
   assign tx_full_o  = full_r;
   assign tx_level_o = level_r;
   assign tx_busy_o  = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stb = 1'b0;
   logic [7:0]    dat = 8'h00;
   logic          full, busy, tx;
   logic [LW-1:0] level;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tx_dat_i   (dat),
      .tx_stb_i   (stb),
      .tx_full_o  (full),
      .tx_level_o (level),
      .tx_busy_o  (busy),
      .tx_o       (tx)
   );

   // Wait (bounded) for a start bit, then sample every cycle of the frame.
   // gap = idle cycles seen before the start bit; bad = cycles that broke a
   // bit's level or a wrong start/stop value.
   task automatic capture(output logic [FB-1:0] bits, output int gap,
                          output int bad, output bit tmo);
      bits = '0; gap = 0; bad = 0; tmo = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            tmo = 1'b0;
            break;
         end
         gap++;
      end
      if (!tmo) begin
         for (int b = 0; b < FB; b++) begin
            for (int c = 0; c < CPB; c++) begin
               if (b != 0 || c != 0) @(negedge clk);
               if (c == 0) bits[b] = tx;
               else if (tx !== bits[b]) bad++;
            end
         end
         if (bits[0] !== 1'b0 || bits[FB-1] !== 1'b1) bad++;
      end
   endtask

   task automatic test_reset();
      int bad_idle;
      rst = 1'b1; stb = 1'b1; dat = 8'h5A;
      @(negedge clk);
      vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL reset_tx: got %b want 1", tx); end
      vec_cnt++; if (level !== 3'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", level); end
      vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b want 0", full); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0; stb = 1'b0;
      bad_idle = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) bad_idle++;
      end
      vec_cnt++; if (bad_idle != 0) begin err_cnt++; $display("FAIL reset_strobe_ignored: got %0d active cycles want 0", bad_idle); end
   endtask

   task automatic test_single();
      logic [FB-1:0] fr; int gap, bad; bit tmo; logic [7:0] e;
      fork
         begin
            @(negedge clk);
            dat = 8'hA5; stb = 1'b1; exp_q.push_back(8'hA5);
            @(negedge clk);
            stb = 1'b0;
            vec_cnt++; if (tx !== 1'b1 || level !== 3'd1 || busy !== 1'b1) begin
               err_cnt++; $display("FAIL single_after_push: got tx=%b lvl=%0d busy=%b want 1/1/1", tx, level, busy);
            end
         end
         begin
            @(negedge clk);
            capture(fr, gap, bad, tmo);
         end
      join
      vec_cnt++;
      if (tmo) begin
         err_cnt++; $display("FAIL single_timeout: got no start bit want start bit");
      end else begin
         e = exp_q.pop_front();
         vec_cnt++; if (fr[8:1] !== e) begin err_cnt++; $display("FAIL single_data: got %h want %h", fr[8:1], e); end
         vec_cnt++; if (gap != 1) begin err_cnt++; $display("FAIL single_latency: got %0d want 1", gap); end
         vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL single_bit_timing: got %0d bad want 0", bad); end
         vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy_last_stop: got %b want 1", busy); end
         @(negedge clk);
         vec_cnt++; if (busy !== 1'b0 || tx !== 1'b1) begin
            err_cnt++; $display("FAIL single_busy_end: got busy=%b tx=%b want 0/1", busy, tx);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [FB-1:0] fr; int gap, bad; bit tmo; logic [7:0] e;
      logic [7:0] bytes [3];
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
      repeat (3) @(negedge clk);
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               if (i == 1 || i == 2) begin
                  vec_cnt++; if (level !== 3'd1) begin err_cnt++; $display("FAIL b2b_level_%0d: got %0d want 1", i, level); end
               end
               dat = bytes[i]; stb = 1'b1; exp_q.push_back(bytes[i]);
            end
            @(negedge clk);
            stb = 1'b0;
            vec_cnt++; if (level !== 3'd2) begin err_cnt++; $display("FAIL b2b_level_peak: got %0d want 2", level); end
         end
         begin
            @(negedge clk);
            for (int f = 0; f < 3; f++) begin
               capture(fr, gap, bad, tmo);
               vec_cnt++;
               if (tmo) begin
                  err_cnt++; $display("FAIL b2b_timeout_%0d: got no start bit want start bit", f);
               end else begin
                  e = exp_q.pop_front();
                  vec_cnt++; if (fr[8:1] !== e) begin err_cnt++; $display("FAIL b2b_data_%0d: got %h want %h", f, fr[8:1], e); end
                  vec_cnt++; if (gap != ((f == 0) ? 1 : 0)) begin err_cnt++; $display("FAIL b2b_gap_%0d: got %0d want %0d", f, gap, (f == 0) ? 1 : 0); end
                  vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL b2b_timing_%0d: got %0d bad want 0", f, bad); end
               end
            end
         end
      join
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_busy_last_stop: got %b want 1", busy); end
      @(negedge clk);
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_overflow();
      logic [FB-1:0] fr; int gap, bad; bit tmo; logic [7:0] e;
      repeat (3) @(negedge clk);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               if (i == 4) begin
                  vec_cnt++; if (level !== 3'd3 || full !== 1'b0) begin err_cnt++; $display("FAIL ovf_before_full: got lvl=%0d full=%b want 3/0", level, full); end
               end
               if (i == 5) begin
                  vec_cnt++; if (level !== 3'd4 || full !== 1'b1) begin err_cnt++; $display("FAIL ovf_full: got lvl=%0d full=%b want 4/1", level, full); end
               end
               dat = 8'(i + 1); stb = 1'b1;
               if (i < 5) exp_q.push_back(8'(i + 1));
            end
            @(negedge clk);
            stb = 1'b0;
            vec_cnt++; if (level !== 3'd4 || full !== 1'b1) begin err_cnt++; $display("FAIL ovf_drop: got lvl=%0d full=%b want 4/1", level, full); end
         end
         begin
            @(negedge clk);
            for (int f = 0; f < 5; f++) begin
               capture(fr, gap, bad, tmo);
               vec_cnt++;
               if (tmo) begin
                  err_cnt++; $display("FAIL ovf_timeout_%0d: got no start bit want start bit", f);
               end else begin
                  e = exp_q.pop_front();
                  vec_cnt++; if (fr[8:1] !== e) begin err_cnt++; $display("FAIL ovf_data_%0d: got %h want %h", f, fr[8:1], e); end
                  vec_cnt++; if (bad != 0 || gap != ((f == 0) ? 1 : 0)) begin err_cnt++; $display("FAIL ovf_timing_%0d: got bad=%0d gap=%0d want 0/%0d", f, bad, gap, (f == 0) ? 1 : 0); end
               end
            end
         end
      join
      @(negedge clk);
      vec_cnt++; if (busy !== 1'b0 || level !== 3'd0) begin err_cnt++; $display("FAIL ovf_no_sixth: got busy=%b lvl=%0d want 0/0", busy, level); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [FB-1:0] fr; int gap, bad; bit tmo;
      logic [7:0] bytes [2];
      logic       pars  [2];
      bytes[0] = 8'h07; pars[0] = 1'b1;
      bytes[1] = 8'h03; pars[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         repeat (3) @(negedge clk);
         fork
            begin
               @(negedge clk);
               dat = bytes[k]; stb = 1'b1; exp_q.push_back(bytes[k]);
               @(negedge clk);
               stb = 1'b0;
            end
            begin
               @(negedge clk);
               capture(fr, gap, bad, tmo);
            end
         join
         vec_cnt++;
         if (tmo) begin
            err_cnt++; $display("FAIL par_timeout_%0d: got no start bit want start bit", k);
         end else begin
            vec_cnt++; if (fr[8:1] !== exp_q.pop_front()) begin err_cnt++; $display("FAIL par_data_%0d: got %h want %h", k, fr[8:1], bytes[k]); end
            vec_cnt++; if (fr[9] !== pars[k]) begin err_cnt++; $display("FAIL par_bit_%0d: got %b want %b", k, fr[9], pars[k]); end
            vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL par_timing_%0d: got %0d bad want 0", k, bad); end
            @(negedge clk);
            vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL par_len_%0d: got busy=%b want 0 after 44 cycles", k, busy); end
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      int bad_idle;
      repeat (3) @(negedge clk);
      @(negedge clk);
      dat = 8'hC3; stb = 1'b1; exp_q.push_back(8'hC3);
      @(negedge clk);
      dat = 8'hAA; exp_q.push_back(8'hAA);
      @(negedge clk);
      dat = 8'hBB; exp_q.push_back(8'hBB);
      @(negedge clk);
      stb = 1'b0;
      repeat (15) @(negedge clk);
      // Now inside data bit 3 of 8'hC3 (a 0 bit) with two bytes queued.
      vec_cnt++; if (tx !== 1'b0 || level !== 3'd2) begin err_cnt++; $display("FAIL rstmid_pre: got tx=%b lvl=%0d want 0/2", tx, level); end
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      vec_cnt++; if (tx !== 1'b1) begin err_cnt++; $display("FAIL rstmid_tx: got %b want 1", tx); end
      vec_cnt++; if (level !== 3'd0 || full !== 1'b0) begin err_cnt++; $display("FAIL rstmid_level: got lvl=%0d full=%b want 0/0", level, full); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      bad_idle = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad_idle++;
      end
      vec_cnt++; if (bad_idle != 0) begin err_cnt++; $display("FAIL rstmid_no_frames: got %0d active cycles want 0", bad_idle); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
